alu_sequencer: RTL and testbench

Initiator side of the ALU operation interface. Accepts ALU requests on a valid/ready stream and buffers them in a FIFO. Issues one request per cycle to the combinational ALU through registered operation/operand outputs, captures the ALU result, and returns it in order, tagged, on a valid/ready response stream. Sits between the instruction decode/issue logic and the ALU instance.

---
 rtl/alu_sequencer_pkg.sv | 35 +++
 rtl/alu_sequencer_fifo.sv | 55 +++++
 rtl/alu_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared ALU operation codes, request entry layout and legal-code check
// for the ALU sequencer and its request FIFO.
package alu_sequencer_pkg;

    localparam int REQ_DATA_W = 32;
    localparam int REQ_TAG_W  = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_MUL = 4'h2,
        OP_OR  = 4'h3,
        OP_NOT = 4'h4,
        OP_XOR = 4'h5,
        OP_AND = 4'h6
    } alu_op_e;

    typedef struct packed {
        logic [3:0]            operation;
        logic [REQ_DATA_W-1:0] operand0;
        logic [REQ_DATA_W-1:0] operand1;
        logic [REQ_TAG_W-1:0]  tag;
    } alu_req_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_NOT, OP_XOR, OP_AND: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_sequencer_fifo.sv
// Synchronous request FIFO with occupancy count; the parent never pushes
// when full nor pops when empty.
module alu_request_fifo
    import alu_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  alu_req_t                 push_data_i,
    input  logic                     pop_i,
    output alu_req_t                 head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    alu_req_t        mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/alu_sequencer.sv
// Request FIFO -> registered ALU issue stage -> registered response stage,
// returning tagged ALU results strictly in order.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int DEPTH      = 4
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              req_operation,
    input  logic [DATA_WIDTH-1:0]   req_operand0,
    input  logic [DATA_WIDTH-1:0]   req_operand1,
    input  logic [TAG_WIDTH-1:0]    req_tag,
    output logic [3:0]              alu_operation,
    output logic [DATA_WIDTH-1:0]   alu_operand0,
    output logic [DATA_WIDTH-1:0]   alu_operand1,
    input  logic [DATA_WIDTH-1:0]   alu_dest,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_result,
    output logic [TAG_WIDTH-1:0]    resp_tag,
    output logic                    resp_error,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    busy
);

    alu_req_t push_entry;
    alu_req_t head;
    logic     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic     issue_adv;

    logic                  issue_valid_q, issue_valid_d;
    logic [3:0]            alu_operation_q, alu_operation_d;
    logic [DATA_WIDTH-1:0] alu_operand0_q, alu_operand0_d;
    logic [DATA_WIDTH-1:0] alu_operand1_q, alu_operand1_d;
    logic [TAG_WIDTH-1:0]  issue_tag_q, issue_tag_d;
    logic                  issue_err_q, issue_err_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_result_q, resp_result_d;
    logic [TAG_WIDTH-1:0]  resp_tag_q, resp_tag_d;
    logic                  resp_error_q, resp_error_d;

    assign req_ready = !fifo_full && !reset;
    assign fifo_push = req_valid && req_ready;

    assign push_entry.operation = req_operation;
    assign push_entry.operand0  = req_operand0;
    assign push_entry.operand1  = req_operand1;
    assign push_entry.tag       = req_tag;

    alu_request_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (count)
    );

    always_comb begin
        issue_adv       = issue_valid_q && (!resp_valid_q || resp_ready);
        fifo_pop        = !fifo_empty && (!issue_valid_q || issue_adv);

        issue_valid_d   = issue_valid_q;
        alu_operation_d = alu_operation_q;
        alu_operand0_d  = alu_operand0_q;
        alu_operand1_d  = alu_operand1_q;
        issue_tag_d     = issue_tag_q;
        issue_err_d     = issue_err_q;
        resp_valid_d    = resp_valid_q;
        resp_result_d   = resp_result_q;
        resp_tag_d      = resp_tag_q;
        resp_error_d    = resp_error_q;

        // Illegal codes are replaced by a harmless ADD 0+0 so the ALU never sees them.
        if (fifo_pop) begin
            issue_valid_d = 1'b1;
            issue_tag_d   = head.tag;
            issue_err_d   = !is_legal_op(head.operation);
            if (is_legal_op(head.operation)) begin
                alu_operation_d = head.operation;
                alu_operand0_d  = head.operand0;
                alu_operand1_d  = head.operand1;
            end else begin
                alu_operation_d = OP_ADD;
                alu_operand0_d  = '0;
                alu_operand1_d  = '0;
            end
        end else if (issue_adv) begin
            issue_valid_d = 1'b0;
        end

        if (issue_adv) begin
            resp_valid_d  = 1'b1;
            resp_result_d = issue_err_q ? '0 : alu_dest;
            resp_tag_d    = issue_tag_q;
            resp_error_d  = issue_err_q;
        end else if (resp_ready) begin
            resp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid_q   <= 1'b0;
            alu_operation_q <= '0;
            alu_operand0_q  <= '0;
            alu_operand1_q  <= '0;
            issue_tag_q     <= '0;
            issue_err_q     <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_result_q   <= '0;
            resp_tag_q      <= '0;
            resp_error_q    <= 1'b0;
        end else begin
            issue_valid_q   <= issue_valid_d;
            alu_operation_q <= alu_operation_d;
            alu_operand0_q  <= alu_operand0_d;
            alu_operand1_q  <= alu_operand1_d;
            issue_tag_q     <= issue_tag_d;
            issue_err_q     <= issue_err_d;
            resp_valid_q    <= resp_valid_d;
            resp_result_q   <= resp_result_d;
            resp_tag_q      <= resp_tag_d;
            resp_error_q    <= resp_error_d;
        end
    end

    assign alu_operation = alu_operation_q;
    assign alu_operand0  = alu_operand0_q;
    assign alu_operand1  = alu_operand1_q;
    assign resp_valid    = resp_valid_q;
    assign resp_result   = resp_result_q;
    assign resp_tag      = resp_tag_q;
    assign resp_error    = resp_error_q;
    assign busy          = (count != '0) || issue_valid_q || resp_valid_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer with a behavioural ALU attached.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_operation;
    logic [31:0] req_operand0;
    logic [31:0] req_operand1;
    logic [3:0]  req_tag;
    logic [3:0]  alu_operation;
    logic [31:0] alu_operand0;
    logic [31:0] alu_operand1;
    logic [31:0] alu_dest;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [3:0]  resp_tag;
    logic        resp_error;
    logic [2:0]  count;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    alu_sequencer #(.DATA_WIDTH(32), .TAG_WIDTH(4), .DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_operation (req_operation),
        .req_operand0  (req_operand0),
        .req_operand1  (req_operand1),
        .req_tag       (req_tag),
        .alu_operation (alu_operation),
        .alu_operand0  (alu_operand0),
        .alu_operand1  (alu_operand1),
        .alu_dest      (alu_dest),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_tag      (resp_tag),
        .resp_error    (resp_error),
        .count         (count),
        .busy          (busy)
    );

    always_comb begin
        alu_dest = '0;
        case (alu_operation)
            OP_ADD:  alu_dest = alu_operand0 + alu_operand1;
            OP_SUB:  alu_dest = alu_operand0 - alu_operand1;
            OP_MUL:  alu_dest = alu_operand0 * alu_operand1;
            OP_OR:   alu_dest = alu_operand0 | alu_operand1;
            OP_NOT:  alu_dest = ~alu_operand0;
            OP_XOR:  alu_dest = alu_operand0 ^ alu_operand1;
            OP_AND:  alu_dest = alu_operand0 & alu_operand1;
            default: alu_dest = '0;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] tag);
        req_valid     = 1'b1;
        req_operation = op;
        req_operand0  = a;
        req_operand1  = b;
        req_tag       = tag;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_operation = '0; req_operand0 = '0; req_operand1 = '0; req_tag = '0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++; $display("FAIL reset_req_ready_low: got %b expected 0", req_ready);
        end
        cyc();
        checks++;
        if (resp_valid !== 1'b0 || resp_result !== 32'h0 || resp_tag !== 4'h0 || resp_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_resp: got v=%b r=%h t=%h e=%b expected all zero",
                     resp_valid, resp_result, resp_tag, resp_error);
        end
        checks++;
        if (alu_operation !== 4'h0 || alu_operand0 !== 32'h0 || alu_operand1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_alu: got op=%h a=%h b=%h expected zeros", alu_operation, alu_operand0, alu_operand1);
        end
        checks++;
        if (count !== 3'd0 || busy !== 1'b0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_count_busy: got count=%0d busy=%b ready=%b expected 0 0 0", count, busy, req_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL post_reset_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_single_add();
        resp_ready = 1'b1;
        drive_req(OP_ADD, 32'd5, 32'd7, 4'd3);
        cyc();
        req_valid = 1'b0;
        checks++;
        if (count !== 3'd1 || resp_valid !== 1'b0) begin
            failures++; $display("FAIL add_n1: got count=%0d v=%b expected 1 0", count, resp_valid);
        end
        cyc();
        checks++;
        if (resp_valid !== 1'b0 || alu_operation !== OP_ADD || alu_operand0 !== 32'd5 || alu_operand1 !== 32'd7) begin
            failures++;
            $display("FAIL add_issue: got v=%b op=%h a=%h b=%h expected 0 0 5 7",
                     resp_valid, alu_operation, alu_operand0, alu_operand1);
        end
        cyc();
        checks++;
        if (resp_valid !== 1'b1 || resp_result !== 32'd12 || resp_tag !== 4'd3 || resp_error !== 1'b0) begin
            failures++;
            $display("FAIL add_resp: got v=%b r=%h t=%h e=%b expected 1 c 3 0",
                     resp_valid, resp_result, resp_tag, resp_error);
        end
        cyc();
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL add_idle: got v=%b busy=%b expected 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  op  [4];
        logic [31:0] a   [4];
        logic [31:0] b   [4];
        logic [31:0] exp_r [4];
        int k, last_c;
        op    = '{OP_SUB, OP_MUL, OP_NOT, OP_XOR};
        a     = '{32'h0, 32'h10000, 32'h0, 32'hF0F0};
        b     = '{32'h1, 32'h10000, 32'h0, 32'h0FF0};
        exp_r = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFF00};
        k = 0; last_c = -1;
        resp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) drive_req(op[c], a[c], b[c], 4'(c + 1));
            else       req_valid = 1'b0;
            cyc();
            if (resp_valid === 1'b1) begin
                checks++;
                if (k >= 4) begin
                    failures++; $display("FAIL b2b_extra: got response %0d expected 4", k + 1);
                end else if (resp_result !== exp_r[k] || resp_tag !== 4'(k + 1) || resp_error !== 1'b0
                             || (k != 0 && c != last_c + 1)) begin
                    failures++;
                    $display("FAIL b2b_resp%0d: got r=%h t=%h e=%b gap=%0d expected r=%h t=%h e=0 gap=1",
                             k, resp_result, resp_tag, resp_error, c - last_c, exp_r[k], 4'(k + 1));
                end
                last_c = c;
                k++;
            end
        end
        checks++;
        if (k != 4) begin
            failures++; $display("FAIL b2b_count: got %0d responses expected 4", k);
        end
    endtask

    task automatic test_fill_drain();
        int acc, k;
        acc = 0; k = 0;
        resp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive_req(OP_ADD, 32'(acc), 32'd100, 4'(acc + 8));
            if (req_ready === 1'b1) acc++;
            cyc();
        end
        req_valid = 1'b0;
        checks++;
        if (acc != 6 || count !== 3'd4 || req_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL fill: got acc=%0d count=%0d ready=%b busy=%b expected 6 4 0 1", acc, count, req_ready, busy);
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++; $display("FAIL no_passthrough: got ready=%b expected 0", req_ready);
        end
        for (int c = 0; c < 20; c++) begin
            if (resp_valid === 1'b1) begin
                checks++;
                if (resp_result !== 32'(k + 100) || resp_tag !== 4'(k + 8) || resp_error !== 1'b0) begin
                    failures++;
                    $display("FAIL drain%0d: got r=%h t=%h e=%b expected r=%h t=%h e=0",
                             k, resp_result, resp_tag, resp_error, 32'(k + 100), 4'(k + 8));
                end
                k++;
            end
            cyc();
        end
        checks++;
        if (k != 6 || count !== 3'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL drain_end: got k=%0d count=%0d busy=%b expected 6 0 0", k, count, busy);
        end
    endtask

    task automatic test_illegal();
        resp_ready = 1'b1;
        drive_req(4'hF, 32'd9, 32'd9, 4'd5);
        cyc();
        req_valid = 1'b0;
        cyc();
        checks++;
        if (alu_operation !== OP_ADD || alu_operand0 !== 32'h0 || alu_operand1 !== 32'h0) begin
            failures++;
            $display("FAIL illegal_issue: got op=%h a=%h b=%h expected 0 0 0", alu_operation, alu_operand0, alu_operand1);
        end
        cyc();
        checks++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_result !== 32'h0 || resp_tag !== 4'd5) begin
            failures++;
            $display("FAIL illegal_resp: got v=%b e=%b r=%h t=%h expected 1 1 0 5",
                     resp_valid, resp_error, resp_result, resp_tag);
        end
        cyc();
    endtask

    task automatic test_hold();
        resp_ready = 1'b0;
        drive_req(OP_AND, 32'hFF00FF00, 32'h0F0F0F0F, 4'd6);
        cyc();
        drive_req(OP_OR, 32'd1, 32'd2, 4'd7);
        cyc();
        req_valid = 1'b0;
        cyc();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_result !== 32'h0F000F00 || resp_tag !== 4'd6 || resp_error !== 1'b0
                || alu_operation !== OP_OR || alu_operand0 !== 32'd1 || alu_operand1 !== 32'd2) begin
                failures++;
                $display("FAIL hold%0d: got v=%b r=%h t=%h op=%h a=%h b=%h expected 1 0f000f00 6 3 1 2",
                         c, resp_valid, resp_result, resp_tag, alu_operation, alu_operand0, alu_operand1);
            end
            cyc();
        end
        resp_ready = 1'b1;
        cyc();
        checks++;
        if (resp_valid !== 1'b1 || resp_result !== 32'd3 || resp_tag !== 4'd7) begin
            failures++;
            $display("FAIL hold_release: got v=%b r=%h t=%h expected 1 3 7", resp_valid, resp_result, resp_tag);
        end
        cyc();
    endtask

    task automatic test_reset_midflight();
        resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_req(OP_ADD, 32'(c), 32'd1, 4'(c + 1));
            cyc();
        end
        req_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || count !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midflight_reset: got v=%b count=%0d busy=%b expected 0 0 0", resp_valid, count, busy);
        end
        resp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            checks++;
            if (resp_valid !== 1'b0) begin
                failures++; $display("FAIL stale_resp%0d: got v=%b t=%h expected 0", c, resp_valid, resp_tag);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_fill_drain();
        test_illegal();
        test_hold();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
